up_axi_bridge: RTL

//  AXI4-Lite slave to pcore up-bus bridge; successor of the single-strobe up-bus bridge.

---
 rtl/up_axi_pkg.sv | 21 ++
 rtl/up_axi_timeout.sv | 29 ++
 rtl/up_axi_bridge.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/up_axi_pkg.sv
// Shared types for the AXI4-Lite to pcore up-bus bridge.
package up_axi_pkg;

    typedef enum logic [1:0] {
        W_IDLE,
        W_REQ,
        W_WAIT,
        W_RESP
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_WAIT,
        R_DATA
    } r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/up_axi_timeout.sv
// Ack-wait cycle counter; expired flags the last cycle of the wait window.
module up_axi_timeout #(
    parameter int CYCLES = 8
) (
    input  logic up_clk,
    input  logic up_rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expired = en && (count == LAST);

endmodule

// File: rtl/up_axi_bridge.sv
// AXI4-Lite slave to pcore up-bus bridge with independent read/write FSMs.
module up_axi_bridge
    import up_axi_pkg::*;
#(
    parameter int          ADDRESS_WIDTH  = 8,
    parameter int          TIMEOUT_CYCLES = 8,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hdeaddead,
    parameter bit          ERR_RESP_EN    = 1'b1
) (
    input  logic                     up_clk,
    input  logic                     up_rstn,
    input  logic                     up_axi_awvalid,
    output logic                     up_axi_awready,
    input  logic [31:0]              up_axi_awaddr,
    input  logic                     up_axi_wvalid,
    output logic                     up_axi_wready,
    input  logic [31:0]              up_axi_wdata,
    input  logic [3:0]               up_axi_wstrb,
    output logic                     up_axi_bvalid,
    input  logic                     up_axi_bready,
    output logic [1:0]               up_axi_bresp,
    input  logic                     up_axi_arvalid,
    output logic                     up_axi_arready,
    input  logic [31:0]              up_axi_araddr,
    output logic                     up_axi_rvalid,
    input  logic                     up_axi_rready,
    output logic [1:0]               up_axi_rresp,
    output logic [31:0]              up_axi_rdata,
    output logic                     up_wreq,
    output logic [ADDRESS_WIDTH-1:0] up_waddr,
    output logic [31:0]              up_wdata,
    output logic [3:0]               up_wstrb,
    input  logic                     up_wack,
    output logic                     up_rreq,
    output logic [ADDRESS_WIDTH-1:0] up_raddr,
    input  logic [31:0]              up_rdata,
    input  logic                     up_rack,
    output logic                     up_timeout
);

    localparam logic [1:0] RESP_ERR = ERR_RESP_EN ? RESP_SLVERR : RESP_OKAY;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic alive;
    logic aw_held, w_held;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic w_ok, w_to, r_ok, r_to;
    logic w_expired, r_expired;
    logic unused_addr;

    assign unused_addr = ^{up_axi_awaddr[31:ADDRESS_WIDTH+2], up_axi_awaddr[1:0],
                           up_axi_araddr[31:ADDRESS_WIDTH+2], up_axi_araddr[1:0]};

    // Ready outputs stay low while in reset, then follow the held flags.
    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) alive <= 1'b0;
        else          alive <= 1'b1;
    end

    assign up_axi_awready = alive && (w_state == W_IDLE) && !aw_held;
    assign up_axi_wready  = alive && (w_state == W_IDLE) && !w_held;
    assign up_axi_arready = alive && (r_state == R_IDLE);

    assign aw_hs = up_axi_awvalid && up_axi_awready;
    assign w_hs  = up_axi_wvalid && up_axi_wready;
    assign b_hs  = up_axi_bvalid && up_axi_bready;
    assign ar_hs = up_axi_arvalid && up_axi_arready;
    assign r_hs  = up_axi_rvalid && up_axi_rready;

    assign up_wreq       = (w_state == W_REQ);
    assign up_axi_bvalid = (w_state == W_RESP);
    assign up_rreq       = (r_state == R_REQ);
    assign up_axi_rvalid = (r_state == R_DATA);
    assign up_timeout    = w_to || r_to;

    up_axi_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_w_timeout (
        .up_clk  (up_clk),
        .up_rstn (up_rstn),
        .clr     (w_state != W_WAIT),
        .en      (w_state == W_WAIT),
        .expired (w_expired)
    );

    up_axi_timeout #(.CYCLES(TIMEOUT_CYCLES)) u_r_timeout (
        .up_clk  (up_clk),
        .up_rstn (up_rstn),
        .clr     (r_state != R_WAIT),
        .en      (r_state == R_WAIT),
        .expired (r_expired)
    );

    always_comb begin
        w_next = w_state;
        w_ok   = 1'b0;
        w_to   = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_REQ;
            end
            W_REQ: begin
                w_ok   = up_wack;
                w_next = up_wack ? W_RESP : W_WAIT;
            end
            W_WAIT: begin
                if (up_wack) begin
                    w_ok   = 1'b1;
                    w_next = W_RESP;
                end else if (w_expired) begin
                    w_to   = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (up_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            w_state      <= W_IDLE;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            up_waddr     <= '0;
            up_wdata     <= '0;
            up_wstrb     <= '0;
            up_axi_bresp <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            if (aw_hs) begin
                aw_held  <= 1'b1;
                up_waddr <= up_axi_awaddr[ADDRESS_WIDTH+1:2];
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                up_wdata <= up_axi_wdata;
                up_wstrb <= up_axi_wstrb;
            end
            if (w_ok)      up_axi_bresp <= RESP_OKAY;
            else if (w_to) up_axi_bresp <= RESP_ERR;
            if (b_hs) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                up_axi_bresp <= RESP_OKAY;
            end
        end
    end

    always_comb begin
        r_next = r_state;
        r_ok   = 1'b0;
        r_to   = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (ar_hs) r_next = R_REQ;
            end
            R_REQ: begin
                r_ok   = up_rack;
                r_next = up_rack ? R_DATA : R_WAIT;
            end
            R_WAIT: begin
                if (up_rack) begin
                    r_ok   = 1'b1;
                    r_next = R_DATA;
                end else if (r_expired) begin
                    r_to   = 1'b1;
                    r_next = R_DATA;
                end
            end
            R_DATA: begin
                if (up_axi_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge up_clk or negedge up_rstn) begin
        if (!up_rstn) begin
            r_state      <= R_IDLE;
            up_raddr     <= '0;
            up_axi_rdata <= '0;
            up_axi_rresp <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (ar_hs) up_raddr <= up_axi_araddr[ADDRESS_WIDTH+1:2];
            if (r_ok) begin
                up_axi_rdata <= up_rdata;
                up_axi_rresp <= RESP_OKAY;
            end else if (r_to) begin
                up_axi_rdata <= TIMEOUT_DATA;
                up_axi_rresp <= RESP_ERR;
            end
            if (r_hs) begin
                up_axi_rdata <= '0;
                up_axi_rresp <= RESP_OKAY;
            end
        end
    end

endmodule
